fitness_eval_ctrl: RTL and testbench
====================================

# fitness_eval_ctrl

Sequencing controller for the fitness-evaluation stage of the evolutionary core. It walks every individual of the population and every gene of each chromosome, issuing gene reads to the population memory and clear/enable strobes to the fitness accumulator datapath. It writes each individual's fitness to the fitness memory under a ready handshake and tracks the best individual. It sits between the generation-level scheduler (start/done) and the fitness datapath.

## Interface
- POP_SIZE, 16, individuals per generation (≥2)
- GENE_NUM, 8, genes per chromosome (≥2)
- FIT_W, 12, fitness width
- IDX_W, $clog2(POP_SIZE), individual index width
- GIDX_W, $clog2(GENE_NUM), gene index width

- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  begin evaluation of one generation; sampled only in IDLE
- abort_i  in  1  synchronous abort; return to IDLE next cycle, no done
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse, generation complete
- gene_rd_en_o  out  1  population-memory read strobe (1-cycle read latency)
- ind_idx_o  out  IDX_W  individual being evaluated
- gene_idx_o  out  GIDX_W  gene address for current read
- acc_clr_o  out  1  clear fitness accumulator
- acc_en_o  out  1  accumulate memory read data (gene_rd_en_o delayed 1 cycle)
- fit_i  in  FIT_W  accumulator result, stable during WRITE
- fit_wr_en_o  out  1  fitness-memory write request, held until accepted
- fit_wr_addr_o  out  IDX_W  equals ind_idx_o
- fit_wr_rdy_i  in  1  fitness memory accepts write this cycle
- best_fit_o  out  FIT_W  highest fitness seen this generation
- best_idx_o  out  IDX_W  index of best_fit_o

## Operation
- States: IDLE, CLR, READ, DRAIN, WRITE, DONE.
- IDLE: start_i=1 → CLR; ind_idx←0; start_i ignored in every other state.
- CLR: acc_clr_o=1, gene_idx←0 → READ.
- READ: gene_rd_en_o=1, gene_idx_o addresses gene; gene_idx increments each cycle; after read of gene GENE_NUM-1 → DRAIN (gene_idx does not wrap past GENE_NUM-1).
- DRAIN: no read; the final acc_en_o pulse occurs here → WRITE.
- WRITE: fit_wr_en_o=1 until fit_wr_rdy_i=1. On handshake: if ind_idx=0 or fit_i > best_fit (strictly unsigned), best_fit←fit_i, best_idx←ind_idx. Ties keep the lower index. Then if ind_idx=POP_SIZE-1 → DONE, else ind_idx++ → CLR.
- DONE: done_o=1 → IDLE. best_fit_o/best_idx_o hold until the next start.
- abort_i has priority over every transition: → IDLE, counters cleared, acc_en_o pipeline flushed, best registers untouched.
- All outputs are registered or Moore-decoded; no input-to-output combinational path.

## Timing
- Reset: state IDLE; busy_o, done_o, gene_rd_en_o, acc_clr_o, acc_en_o, fit_wr_en_o = 0; ind_idx_o, gene_idx_o, fit_wr_addr_o, best_idx_o = 0; best_fit_o = 0.
- Reset mid-operation: immediate return to reset values; no partial write.
- Per individual with fit_wr_rdy_i=1: GENE_NUM+3 cycles (CLR 1, READ GENE_NUM, DRAIN 1, WRITE 1).
- With start_i in cycle 0: CLR in cycle 1+i·(GENE_NUM+3). done_o in cycle POP_SIZE·(GENE_NUM+3)+1, i.e. 177 at default parameters.
- Each cycle of fit_wr_rdy_i=0 in WRITE adds exactly one cycle; outputs stay stable while stalled.
- acc_en_o(n) = gene_rd_en_o(n-1) while not aborted: GENE_NUM pulses per individual, the last in DRAIN.
- busy_o rises the cycle after start_i and falls the cycle after done_o.

## Test plan
- Reset then start with fit_wr_rdy_i=1 and defaults → 16 write requests to addresses 0..15, 8 gene reads each (gene_idx 0..7), done_o exactly at cycle 177, busy_o low at 178.
- fit_i = 5,9,9,3,… with a maximum of 40 at index 12 → best_fit_o=40, best_idx_o=12. With a tie of 9 at indices 1 and 2 as maximum → best_idx_o=1.
- fit_wr_rdy_i low for 3 cycles on individual 4 → fit_wr_en_o held with addr 4, done_o delayed to cycle 180, no extra reads.
- abort_i during READ of individual 7 gene 3 → IDLE next cycle, no done_o, no fit_wr_en_o; a new start_i yields a full normal run.
- start_i pulsed while busy, and asserted in the DONE cycle → ignored; only one done_o per accepted start.
- rst_n_i asserted mid-WRITE → all outputs at reset values immediately; fit_wr_en_o low.

Source files
------------

// File: rtl/fitness_eval_ctrl_if.sv
// Controller <-> fitness datapath / memory signals: gene reads, accumulator
// strobes and the fitness-memory write handshake.
interface fitness_eval_ctrl_if #(
    parameter int FIT_W  = 12,
    parameter int IDX_W  = 4,
    parameter int GIDX_W = 3
);
    logic              gene_rd_en;
    logic [IDX_W-1:0]  ind_idx;
    logic [GIDX_W-1:0] gene_idx;
    logic              acc_clr;
    logic              acc_en;
    logic [FIT_W-1:0]  fit;
    logic              fit_wr_en;
    logic [IDX_W-1:0]  fit_wr_addr;
    logic              fit_wr_rdy;

    modport master (
        output gene_rd_en, ind_idx, gene_idx, acc_clr, acc_en,
               fit_wr_en, fit_wr_addr,
        input  fit, fit_wr_rdy
    );

    modport slave (
        input  gene_rd_en, ind_idx, gene_idx, acc_clr, acc_en,
               fit_wr_en, fit_wr_addr,
        output fit, fit_wr_rdy
    );
endinterface

// File: rtl/fitness_eval_ctrl.sv
// Fitness-evaluation sequencer: walks individuals and genes, writes each
// fitness under a ready handshake and tracks the best individual.
module fitness_eval_ctrl #(
    parameter int POP_SIZE = 16,
    parameter int GENE_NUM = 8,
    parameter int FIT_W    = 12,
    parameter int IDX_W    = $clog2(POP_SIZE),
    parameter int GIDX_W   = $clog2(GENE_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [FIT_W-1:0]     best_fit_o,
    output logic [IDX_W-1:0]     best_idx_o,
    fitness_eval_ctrl_if.master  dp
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_READ, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    localparam logic [GIDX_W-1:0] LAST_GENE = GIDX_W'(GENE_NUM - 1);
    localparam logic [IDX_W-1:0]  LAST_IND  = IDX_W'(POP_SIZE - 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ind_idx;
    logic [GIDX_W-1:0] gene_idx;
    logic              acc_en;
    logic [FIT_W-1:0]  best_fit;
    logic [IDX_W-1:0]  best_idx;
    logic              wr_ack;

    assign wr_ack = (state == S_WRITE) && dp.fit_wr_rdy;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_i) state_nxt = S_CLR;
                S_CLR:   state_nxt = S_READ;
                S_READ:  if (gene_idx == LAST_GENE) state_nxt = S_DRAIN;
                S_DRAIN: state_nxt = S_WRITE;
                S_WRITE: if (dp.fit_wr_rdy) state_nxt = (ind_idx == LAST_IND) ? S_DONE : S_CLR;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Counters and the accumulate strobe; acc_en trails the read strobe by the memory latency.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ind_idx  <= '0;
            gene_idx <= '0;
            acc_en   <= 1'b0;
        end else if (abort_i) begin
            ind_idx  <= '0;
            gene_idx <= '0;
            acc_en   <= 1'b0;
        end else begin
            acc_en <= (state == S_READ);
            case (state)
                S_IDLE:  if (start_i) ind_idx <= '0;
                S_CLR:   gene_idx <= '0;
                S_READ:  if (gene_idx != LAST_GENE) gene_idx <= gene_idx + 1'b1;
                S_WRITE: if (dp.fit_wr_rdy && ind_idx != LAST_IND) ind_idx <= ind_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Strict compare keeps the lower index on ties; individual 0 always seeds the search.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            best_fit <= '0;
            best_idx <= '0;
        end else if (wr_ack && !abort_i && (ind_idx == '0 || dp.fit > best_fit)) begin
            best_fit <= dp.fit;
            best_idx <= ind_idx;
        end
    end

    assign busy_o         = (state != S_IDLE);
    assign done_o         = (state == S_DONE);
    assign dp.gene_rd_en  = (state == S_READ);
    assign dp.acc_clr     = (state == S_CLR);
    assign dp.fit_wr_en   = (state == S_WRITE);
    assign dp.acc_en      = acc_en;
    assign dp.ind_idx     = ind_idx;
    assign dp.gene_idx    = gene_idx;
    assign dp.fit_wr_addr = ind_idx;
    assign best_fit_o     = best_fit;
    assign best_idx_o     = best_idx;
endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Scoreboard bench for fitness_eval_ctrl: stimulus queues expected writes and
// done events, a negedge monitor pops and compares them.
module tb_fitness_eval_ctrl;
    typedef struct {
        int cyc;
        int bf;
        int bi;
    } done_t;

    localparam logic [11:0] T1 [16] = '{12'd5, 12'd9, 12'd9, 12'd3, 12'd7, 12'd1, 12'd0, 12'd2,
                                        12'd11, 12'd4, 12'd6, 12'd8, 12'd40, 12'd13, 12'd39, 12'd10};
    localparam logic [11:0] T2 [16] = '{12'd5, 12'd9, 12'd9, 12'd3, 12'd1, 12'd0, 12'd2, 12'd4,
                                        12'd6, 12'd8, 12'd7, 12'd1, 12'd0, 12'd2, 12'd3, 12'd4};
    localparam logic [11:0] T3 [16] = '{12'd4095, 12'd12, 12'd100, 12'd7, 12'd4094, 12'd0, 12'd1, 12'd2,
                                        12'd3, 12'd4, 12'd5, 12'd6, 12'd8, 12'd9, 12'd10, 12'd4095};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rdy = 1'b1;
    logic        busy, done;
    logic [11:0] best_fit;
    logic [3:0]  best_idx;
    logic [11:0] fit_tbl [16];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_ind = 0;
    int stall_left = 0;
    int rd_cnt = 0;
    bit prev_rd = 1'b0;
    bit prev_ab = 1'b0;
    int    wr_q [$];
    done_t done_q [$];

    fitness_eval_ctrl_if #(.FIT_W(12), .IDX_W(4), .GIDX_W(3)) bus ();

    fitness_eval_ctrl dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .abort_i    (abort),
        .busy_o     (busy),
        .done_o     (done),
        .best_fit_o (best_fit),
        .best_idx_o (best_idx),
        .dp         (bus)
    );

    assign bus.fit        = fit_tbl[bus.fit_wr_addr];
    assign bus.fit_wr_rdy = rdy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: event seen, want none", nm);
    endtask

    // Monitor: checks reads, writes, acc_en alignment and done against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_q.delete();
            done_q.delete();
            rd_cnt  = 0;
            prev_rd = 1'b0;
            prev_ab = 1'b0;
        end else begin
            chk("acc_en", int'(bus.acc_en), int'(prev_rd && !prev_ab));
            if (bus.gene_rd_en) begin
                if (wr_q.size() == 0) flag("unexpected_read");
                else begin
                    chk("rd_ind_idx", int'(bus.ind_idx), wr_q[0]);
                    chk("rd_gene_idx", int'(bus.gene_idx), rd_cnt);
                end
                rd_cnt++;
            end
            if (bus.fit_wr_en) begin
                if (wr_q.size() == 0) flag("unexpected_write");
                else begin
                    chk("wr_addr", int'(bus.fit_wr_addr), wr_q[0]);
                    if (rdy) begin
                        chk("reads_per_ind", rd_cnt, 8);
                        void'(wr_q.pop_front());
                        rd_cnt = 0;
                    end
                end
            end
            if (done) begin
                if (done_q.size() == 0) flag("unexpected_done");
                else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("best_fit", int'(best_fit), d.bf);
                    chk("best_idx", int'(best_idx), d.bi);
                    chk("wr_q_empty_at_done", wr_q.size(), 0);
                end
            end
            prev_rd = bus.gene_rd_en;
            prev_ab = abort;
            if (abort) begin
                wr_q.delete();
                done_q.delete();
                rd_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.fit_wr_en && int'(bus.fit_wr_addr) == stall_ind && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end else begin
            rdy = 1'b1;
        end
    endtask

    task automatic launch(input int exp_len, input int bf, input int bi);
        for (int i = 0; i < 16; i++) wr_q.push_back(i);
        start = 1'b1;
        done_q.push_back('{cyc + exp_len, bf, bi});
        tick();
        start = 1'b0;
        chk("busy_rise", int'(busy), 1);
    endtask

    task automatic run_gen(input int exp_len, input int bf, input int bi, input bit pulse);
        int n;
        launch(exp_len, bf, bi);
        n = 0;
        while (!done && n < 400) begin
            if (pulse && n == 30) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        if (!done) begin
            flag("done_timeout");
            return;
        end
        if (pulse) start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_fall", int'(busy), 0);
        chk("done_pulse_width", int'(done), 0);
        repeat (10) tick();
        chk("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation bound reached");
        $fatal(1);
    end

    initial begin
        int n;
        fit_tbl = T1;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(bus.gene_rd_en), 0);
        chk("rst_acc_clr", int'(bus.acc_clr), 0);
        chk("rst_acc_en", int'(bus.acc_en), 0);
        chk("rst_wr_en", int'(bus.fit_wr_en), 0);
        chk("rst_ind_idx", int'(bus.ind_idx), 0);
        chk("rst_gene_idx", int'(bus.gene_idx), 0);
        chk("rst_best_fit", int'(best_fit), 0);
        chk("rst_best_idx", int'(best_idx), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Normal run, max 40 at index 12, start pulsed mid-run and in the DONE cycle.
        run_gen(177, 40, 12, 1'b1);

        // 3-cycle write stall on individual 4; boundary values 4095 tie at 0 and 15.
        fit_tbl = T3;
        stall_ind = 4;
        stall_left = 3;
        run_gen(180, 4095, 0, 1'b0);

        // Abort during READ of individual 7 gene 3.
        fit_tbl = T1;
        launch(177, 40, 12);
        n = 0;
        while (!(bus.gene_rd_en && bus.ind_idx == 4'd7 && bus.gene_idx == 3'd3) && n < 300) begin
            tick();
            n++;
        end
        chk("abort_reached_target", int'(bus.gene_rd_en && bus.ind_idx == 4'd7 && bus.gene_idx == 3'd3), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rd_en", int'(bus.gene_rd_en), 0);
        chk("abort_acc_en", int'(bus.acc_en), 0);
        chk("abort_wr_en", int'(bus.fit_wr_en), 0);
        chk("abort_ind_idx", int'(bus.ind_idx), 0);
        repeat (20) tick();
        chk("abort_stays_idle", int'(busy), 0);

        // Full run after abort; tie of 9 at indices 1 and 2 keeps index 1.
        fit_tbl = T2;
        run_gen(177, 9, 1, 1'b0);

        // Reset asserted while stalled in WRITE of individual 2.
        fit_tbl = T1;
        stall_ind = 2;
        stall_left = 1000;
        launch(177, 40, 12);
        n = 0;
        while (!(bus.fit_wr_en && bus.fit_wr_addr == 4'd2 && !rdy) && n < 200) begin
            tick();
            n++;
        end
        chk("rst_test_reached_write", int'(bus.fit_wr_en && bus.fit_wr_addr == 4'd2), 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_wr_en", int'(bus.fit_wr_en), 0);
        chk("midrst_wr_addr", int'(bus.fit_wr_addr), 0);
        chk("midrst_gene_idx", int'(bus.gene_idx), 0);
        chk("midrst_acc_en", int'(bus.acc_en), 0);
        chk("midrst_best_fit", int'(best_fit), 0);
        chk("midrst_best_idx", int'(best_idx), 0);
        stall_left = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
